// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants and sync polarity encoding.
// Shared by vga_sync_gen and vga_axis_counter.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CNT_W    = 10;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  // Sync polarity: the level driven while the sync pulse is active.
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam int unsigned FRAME_CNT_W = 8;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..MAX counter for one VGA axis; wrap flags the final count while inc is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX = DEF_H_TOTAL - 1,
  parameter int unsigned W   = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  assign wrap = inc && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: sync, active-video flag, coordinates and line/frame strobes.
// Optional VGA_SYNC_FRAMECNT_EN adds an 8-bit frame counter output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetN,
  output logic             hsync,
  output logic             vsync,
  output logic             videoOn,
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] pixelY,
  output logic             lineTick,
  output logic             frameTick
`ifdef VGA_SYNC_FRAMECNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frameCnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_LIM    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LIM    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hCnt;
  logic [CNT_W-1:0] vCnt;
  logic             hWrap;
  logic             vWrap;
  logic             hSyncOn;
  logic             vSyncOn;

  vga_axis_counter #(
    .MAX (H_TOTAL - 1),
    .W   (CNT_W)
  ) uHorz (
    .clk    (clk),
    .resetN (resetN),
    .inc    (1'b1),
    .cnt    (hCnt),
    .wrap   (hWrap)
  );

  // Vertical axis advances once per line; its wrap marks the last pixel of the frame.
  vga_axis_counter #(
    .MAX (V_TOTAL - 1),
    .W   (CNT_W)
  ) uVert (
    .clk    (clk),
    .resetN (resetN),
    .inc    (hWrap),
    .cnt    (vCnt),
    .wrap   (vWrap)
  );

  assign hSyncOn = (hCnt >= H_SYNC_START) && (hCnt <= H_SYNC_END);
  assign vSyncOn = (vCnt >= V_SYNC_START) && (vCnt <= V_SYNC_END);

  // One register stage so coordinates and sync/video flags stay aligned.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      videoOn   <= 1'b0;
      pixelX    <= '0;
      pixelY    <= '0;
      lineTick  <= 1'b0;
      frameTick <= 1'b0;
    end else begin
      hsync     <= hSyncOn ? SYNC_POL : ~SYNC_POL;
      vsync     <= vSyncOn ? SYNC_POL : ~SYNC_POL;
      videoOn   <= (hCnt < H_ACT_LIM) && (vCnt < V_ACT_LIM);
      pixelX    <= hCnt;
      pixelY    <= vCnt;
      lineTick  <= hWrap;
      frameTick <= vWrap;
    end
  end

`ifdef VGA_SYNC_FRAMECNT_EN
  // Game-speed timebase: counts visible frameTick pulses, wrapping naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      frameCnt <= '0;
    end else if (frameTick) begin
      frameCnt <= frameCnt + FRAME_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size line timing plus a shrunk, high-polarity
// instance for frame, mid-frame reset and (with VGA_SYNC_FRAMECNT_EN) frame counter checks.
module tb_vga_sync_gen;

  // Shrunk timing: H 8+2+3+2 = 15, V 6+1+2+3 = 12, frame = 180 cycles.
  localparam int unsigned S_HTOT = 15;
  localparam int unsigned S_VTOT = 12;
  localparam int unsigned S_FRAME = S_HTOT * S_VTOT;

  logic clk = 1'b0;
  logic rstDefN;
  logic rstSmlN;

  logic       hsD, vsD, vonD, ltD, ftD;
  logic [9:0] pxD, pyD;
  logic       hsS, vsS, vonS, ltS, ftS;
  logic [9:0] pxS, pyS;
`ifdef VGA_SYNC_FRAMECNT_EN
  logic [7:0] fcD, fcS;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  vga_sync_gen dutDef (
    .clk       (clk),
    .resetN    (rstDefN),
    .hsync     (hsD),
    .vsync     (vsD),
    .videoOn   (vonD),
    .pixelX    (pxD),
    .pixelY    (pyD),
    .lineTick  (ltD),
    .frameTick (ftD)
`ifdef VGA_SYNC_FRAMECNT_EN
    ,
    .frameCnt  (fcD)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1), .CNT_W (10)
  ) dutSml (
    .clk       (clk),
    .resetN    (rstSmlN),
    .hsync     (hsS),
    .vsync     (vsS),
    .videoOn   (vonS),
    .pixelX    (pxS),
    .pixelY    (pyS),
    .lineTick  (ltS),
    .frameTick (ftS)
`ifdef VGA_SYNC_FRAMECNT_EN
    ,
    .frameCnt  (fcS)
`endif
  );

  task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vonCnt, hsLowCnt, hsFirstX, ltCnt, ltX, ftCnt, badX, vsHighCnt;
    int vsFirstY, hsHighCnt, ftIdx0, ftIdx1, ltFirst, found;

    rstDefN = 1'b0;
    rstSmlN = 1'b0;

    // Reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkEq("rst_hsync_def", hsD, 1);
      checkEq("rst_vsync_def", vsD, 1);
      checkEq("rst_von_def", vonD, 0);
    end
    checkEq("rst_px_def", pxD, 0);
    checkEq("rst_lt_def", ltD, 0);
    checkEq("rst_hsync_sml", hsS, 0);
    checkEq("rst_vsync_sml", vsS, 0);

    rstDefN = 1'b1;
    rstSmlN = 1'b1;
    #1;
    checkEq("release_hold_von", vonD, 0);
    stepCycle();
    checkEq("first_px", pxD, 0);
    checkEq("first_py", pyD, 0);
    checkEq("first_von", vonD, 1);
    checkEq("first_px_sml", pxS, 0);
    checkEq("first_von_sml", vonS, 1);

    // One full default line, sample index i shows pixelX = i
    vonCnt = 0; hsLowCnt = 0; hsFirstX = -1; ltCnt = 0; ltX = -1; ftCnt = 0; badX = 0;
    for (int i = 0; i < 800; i++) begin
      if (pxD != 10'(i) || pyD != 10'd0) badX++;
      if (vonD) vonCnt++;
      if (!hsD) begin
        hsLowCnt++;
        if (hsFirstX < 0) hsFirstX = int'(pxD);
      end
      if (ltD) begin
        ltCnt++;
        ltX = int'(pxD);
      end
      if (ftD) ftCnt++;
      stepCycle();
    end
    checkEq("line_coord_errs", badX, 0);
    checkEq("line_von_cnt", vonCnt, 640);
    checkEq("line_hs_low_cnt", hsLowCnt, 96);
    checkEq("line_hs_first_x", hsFirstX, 656);
    checkEq("line_lt_cnt", ltCnt, 1);
    checkEq("line_lt_x", ltX, 799);
    checkEq("line_ft_cnt", ftCnt, 0);
    checkEq("line_next_px", pxD, 0);
    checkEq("line_next_py", pyD, 1);
    checkEq("line_vsync_idle", vsD, 1);

    // Small instance: realign to a fresh frame start
    rstSmlN = 1'b0;
    stepCycle();
    rstSmlN = 1'b1;
    stepCycle();
    checkEq("sml_realign_px", pxS, 0);

    // Two small frames, high-polarity sync
    vonCnt = 0; hsHighCnt = 0; hsFirstX = -1; vsHighCnt = 0; vsFirstY = -1;
    ltCnt = 0; ftCnt = 0; ftIdx0 = -1; ftIdx1 = -1;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      if (vonS) vonCnt++;
      if (hsS) begin
        hsHighCnt++;
        if (hsFirstX < 0) hsFirstX = int'(pxS);
      end
      if (vsS) begin
        vsHighCnt++;
        if (vsFirstY < 0) vsFirstY = int'(pyS);
      end
      if (ltS) ltCnt++;
      if (ftS) begin
        ftCnt++;
        if (ftIdx0 < 0) ftIdx0 = i;
        else ftIdx1 = i;
      end
      stepCycle();
    end
    checkEq("frm_von_cnt", vonCnt, 96);
    checkEq("frm_hs_high_cnt", hsHighCnt, 72);
    checkEq("frm_hs_first_x", hsFirstX, 10);
    checkEq("frm_vs_high_cnt", vsHighCnt, 60);
    checkEq("frm_vs_first_y", vsFirstY, 7);
    checkEq("frm_lt_cnt", ltCnt, 24);
    checkEq("frm_ft_cnt", ftCnt, 2);
    checkEq("frm_ft_first_idx", ftIdx0, 179);
    checkEq("frm_ft_period", ftIdx1 - ftIdx0, S_FRAME);

    // Mid-frame reset at (4,3)
    found = 0;
    for (int i = 0; i < 2 * S_FRAME && found == 0; i++) begin
      if (pxS == 10'd4 && pyS == 10'd3) found = 1;
      else stepCycle();
    end
    checkEq("mid_reach_target", found, 1);
    rstSmlN = 1'b0;
    stepCycle();
    checkEq("mid_rst_px", pxS, 0);
    checkEq("mid_rst_py", pyS, 0);
    checkEq("mid_rst_von", vonS, 0);
    checkEq("mid_rst_hs", hsS, 0);
    checkEq("mid_rst_lt", ltS, 0);
    checkEq("mid_rst_ft", ftS, 0);
    rstSmlN = 1'b1;
    stepCycle();
    checkEq("mid_restart_px", pxS, 0);
    checkEq("mid_restart_py", pyS, 0);
    checkEq("mid_restart_von", vonS, 1);
    ltCnt = 0; ltFirst = -1; ftCnt = 0; ftIdx0 = -1;
    for (int i = 0; i < S_FRAME; i++) begin
      if (ltS) begin
        ltCnt++;
        if (ltFirst < 0) ltFirst = i;
      end
      if (ftS) begin
        ftCnt++;
        ftIdx0 = i;
      end
      stepCycle();
    end
    checkEq("mid_lt_first_idx", ltFirst, 14);
    checkEq("mid_lt_cnt", ltCnt, 12);
    checkEq("mid_ft_cnt", ftCnt, 1);
    checkEq("mid_ft_idx", ftIdx0, 179);

`ifdef VGA_SYNC_FRAMECNT_EN
    // Frame counter wrap over 257 small frames
    rstSmlN = 1'b0;
    stepCycle();
    rstSmlN = 1'b1;
    stepCycle();
    checkEq("fc_start", fcS, 0);
    for (int f = 1; f <= 257; f++) begin
      for (int c = 0; c < S_FRAME; c++) stepCycle();
      if (f == 255) checkEq("fc_255", fcS, 255);
      if (f == 256) checkEq("fc_wrap_0", fcS, 0);
      if (f == 257) checkEq("fc_after_wrap_1", fcS, 1);
    end
    checkEq("fc_def_idle", fcD, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
